// File: rtl/shift_result_wb_buffer_pkg.sv
// Shared widths, register constants and the pending-entry record for the EX->WB buffer.
package shift_result_wb_buffer_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned NUM_REGS = 1 << REG_AW;

    localparam logic [REG_AW-1:0] ZERO_REG = '0;

    // One pending result; zero is the data==0 flag captured at enqueue.
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data;
        logic              zero;
    } wb_entry_t;

endpackage

// File: rtl/shift_result_wb_buffer_if.sv
// Result handshake from the shift/ALU stage into the writeback buffer.
interface shift_result_wb_buffer_if;
    import shift_result_wb_buffer_pkg::*;

    logic              valid;
    logic              ready;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;

    modport master (output valid, output rd, output data, input ready);
    modport slave  (input valid, input rd, input data, output ready);

endinterface

// File: rtl/shift_result_wb_buffer_wb_entry_fifo.sv
// Circular DEPTH-entry store of pending writeback results with head/tail/count bookkeeping.
module wb_entry_fifo
    import shift_result_wb_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  wb_entry_t        wr_entry,
    output wb_entry_t        entries [DEPTH],
    output logic [PTR_W-1:0] head,
    output logic [CNT_W-1:0] count
);

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q, count_d;

    // Occupancy next state; the caller never pushes when full or pops when empty.
    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer, occupancy and storage update; flush only invalidates, it does not clear storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem_q[tail_q] <= wr_entry;
                tail_q        <= tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_q <= head_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    assign entries = mem_q;
    assign head    = head_q;
    assign count   = count_q;

endmodule

// File: rtl/shift_result_wb_buffer.sv
// EX->WB result buffer: handshake glue, R0 drop, FIFO drain to the RF port and forwarding lookup.
module shift_result_wb_buffer
    import shift_result_wb_buffer_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter bit          DROP_R0 = 1'b1,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    shift_result_wb_buffer_if.slave in_bus,
    input  logic                    wb_stall,
    output logic                    rf_we,
    output logic [REG_AW-1:0]       rf_waddr,
    output logic [DATA_W-1:0]       rf_wdata,
    output logic                    rf_zero,
    input  logic [REG_AW-1:0]       fwd_raddr,
    output logic                    fwd_hit,
    output logic [DATA_W-1:0]       fwd_data,
    output logic [CNT_W-1:0]        count
);

    wb_entry_t        entries [DEPTH];
    wb_entry_t        wr_entry;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] idx;
    logic             push, store, pop;
    logic             fwd_block;

    // Ready depends on state only so upstream never sees a valid->ready loop.
    assign in_bus.ready = (count != CNT_W'(DEPTH));

    assign push  = in_bus.valid & in_bus.ready & ~flush;
    // R0 results complete the handshake but are never queued.
    assign store = push & ~(DROP_R0 & (in_bus.rd == ZERO_REG));
    // Reset gating keeps the RF quiet during a mid-operation reset.
    assign pop   = (count != '0) & ~wb_stall & ~flush & ~rst;

    assign wr_entry = '{rd: in_bus.rd, data: in_bus.data, zero: (in_bus.data == '0)};

    wb_entry_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .push     (store),
        .pop      (pop),
        .wr_entry (wr_entry),
        .entries  (entries),
        .head     (head),
        .count    (count)
    );

    assign rf_we    = pop;
    assign rf_waddr = entries[head].rd;
    assign rf_wdata = entries[head].data;
    assign rf_zero  = entries[head].zero;

    assign fwd_block = DROP_R0 & (fwd_raddr == ZERO_REG);

    // Walk valid entries oldest to youngest so the youngest match overwrites earlier ones.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (entries[idx].rd == fwd_raddr) && !fwd_block) begin
                fwd_hit  = 1'b1;
                fwd_data = entries[idx].data;
            end
        end
    end

endmodule

// File: tb/tb_shift_result_wb_buffer.sv
// Self-checking bench: directed scenarios then random traffic against a queue-based model.
module tb_shift_result_wb_buffer;

    localparam int unsigned DEPTH = 2;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        zero;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        wb_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        rf_zero;
    logic [4:0]  fwd_raddr;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic [1:0]  count;

    int vectors;
    int miscompares;
    ent_t q[$];

    shift_result_wb_buffer_if bus ();

    shift_result_wb_buffer #(
        .DEPTH   (DEPTH),
        .DROP_R0 (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_bus    (bus),
        .wb_stall  (wb_stall),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .rf_zero   (rf_zero),
        .fwd_raddr (fwd_raddr),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data),
        .count     (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs, check outputs against the model, clock, update the model.
    task automatic step(input logic r, input logic f, input logic v, input logic s,
                        input logic [4:0] rd_v, input logic [31:0] d, input logic [4:0] fa,
                        input logic zero_head);
        logic        exp_we, exp_push, exp_hit;
        logic [31:0] exp_fd;
        rst       = r;
        flush     = f;
        bus.valid = v;
        bus.rd    = rd_v;
        bus.data  = d;
        wb_stall  = s;
        fwd_raddr = fa;
        #1;
        exp_we  = (q.size() != 0) && !s && !f && !r;
        exp_hit = 1'b0;
        exp_fd  = 32'h0;
        if (fa != 5'd0) begin
            for (int i = 0; i < q.size(); i++) begin
                if (q[i].rd == fa) begin
                    exp_hit = 1'b1;
                    exp_fd  = q[i].data;
                end
            end
        end
        check("in_ready", 64'(bus.ready), 64'(q.size() != DEPTH));
        check("count", 64'(count), 64'(q.size()));
        check("rf_we", 64'(rf_we), 64'(exp_we));
        check("fwd_hit", 64'(fwd_hit), 64'(exp_hit));
        check("fwd_data", 64'(fwd_data), 64'(exp_fd));
        if (q.size() != 0) begin
            check("rf_waddr", 64'(rf_waddr), 64'(q[0].rd));
            check("rf_wdata", 64'(rf_wdata), 64'(q[0].data));
            check("rf_zero", 64'(rf_zero), 64'(q[0].zero));
        end else if (zero_head) begin
            check("rf_waddr_rst", 64'(rf_waddr), 64'h0);
            check("rf_wdata_rst", 64'(rf_wdata), 64'h0);
            check("rf_zero_rst", 64'(rf_zero), 64'h0);
        end
        exp_push = v && (q.size() != DEPTH);
        @(posedge clk);
        if (r || f) begin
            q.delete();
        end else begin
            if (exp_we) void'(q.pop_front());
            if (exp_push && rd_v != 5'd0) q.push_back('{rd: rd_v, data: d, zero: (d == 32'h0)});
        end
        @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1; flush = 1'b0; wb_stall = 1'b0; fwd_raddr = '0;
        bus.valid = 1'b0; bus.rd = '0; bus.data = '0;
        @(negedge clk);

        // Reset held two cycles with valid high.
        step(1, 0, 1, 0, 5'd3, 32'h55, 5'd0, 0);
        step(1, 0, 1, 0, 5'd3, 32'h55, 5'd0, 0);
        step(0, 0, 0, 0, 5'd0, 32'h0, 5'd0, 1);

        // Single push then write-back on the following cycle.
        step(0, 0, 1, 0, 5'd5, 32'h8000_0000, 5'd0, 0);
        step(0, 0, 0, 0, 5'd0, 32'h0, 5'd5, 0);

        // Stall until full; third valid refused; drain in order.
        step(0, 0, 1, 1, 5'd1, 32'h0, 5'd0, 0);
        step(0, 0, 1, 1, 5'd2, 32'h22, 5'd1, 0);
        step(0, 0, 1, 1, 5'd3, 32'h33, 5'd2, 0);
        step(0, 0, 0, 0, 5'd0, 32'h0, 5'd3, 0);
        step(0, 0, 0, 0, 5'd0, 32'h0, 5'd0, 0);
        step(0, 0, 0, 0, 5'd0, 32'h0, 5'd0, 0);

        // Youngest-match forwarding, then a miss.
        step(0, 0, 1, 1, 5'd7, 32'h11, 5'd7, 0);
        step(0, 0, 1, 1, 5'd7, 32'h22, 5'd7, 0);
        step(0, 0, 0, 1, 5'd0, 32'h0, 5'd7, 0);
        step(0, 0, 0, 1, 5'd0, 32'h0, 5'd8, 0);

        // Flush with valid high while full, then no further writes.
        step(0, 1, 1, 0, 5'd9, 32'h99, 5'd7, 0);
        step(0, 0, 0, 0, 5'd0, 32'h0, 5'd7, 0);
        step(0, 0, 0, 0, 5'd0, 32'h0, 5'd9, 0);

        // R0 result accepted but dropped.
        step(0, 0, 1, 0, 5'd0, 32'h1, 5'd0, 0);
        step(0, 0, 0, 0, 5'd0, 32'h0, 5'd0, 0);
        step(0, 0, 0, 0, 5'd0, 32'h0, 5'd0, 0);

        // Random traffic over a small register range so forwarding hits often.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] d;
            d = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0),
                 5'($urandom_range(0, 7)), d, 5'($urandom_range(0, 7)), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
